// File: rtl/multiplier_arbiter_tainttrack_pkg.sv
// multiplier_arbiter_pkg: shared FSM type, default sizes and the round-robin wrap helper
package multiplier_arbiter_pkg;
   localparam int WIDTH_DEF   = 128;
   localparam int NUM_REQ_DEF = 4;
   localparam int TIMEOUT_DEF = 4*WIDTH_DEF+8;
   localparam int CNT_W       = $clog2(TIMEOUT_DEF+1);
   localparam int IDX_W       = $clog2(NUM_REQ_DEF);
   typedef enum logic [2:0] {IDLE = 3'd0, START, DRAIN, RUN, RESP} state_e;
   function automatic int rr_wrap(input int base, input int step, input int n);
      return (base + step) % n;
   endfunction
endpackage

// File: rtl/multiplier_arbiter_tainttrack_rr_pick.sv
// rr_pick_tainttrack: first set request after ptr (wrapping), plus taint of the arbitration decision
module rr_pick_tainttrack
   import multiplier_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] req_t,
   input  logic [IW-1:0]      ptr,
   output logic               found,
   output logic [IW-1:0]      idx,
   output logic               grant_t
);
   always_comb begin
      idx = '0;
      // scanning backwards lets the nearest candidate after ptr overwrite the farther ones
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[IW'(rr_wrap(int'(ptr), k, NUM_REQ))]) idx = IW'(rr_wrap(int'(ptr), k, NUM_REQ));
      end
   end
   assign found   = |req;
   assign grant_t = |(req & req_t);
endmodule

// File: rtl/multiplier_arbiter_tainttrack.sv
// multiplier_arbiter_tainttrack: round-robin sharing of one taint-tracked sequential multiplier with a watchdog
module multiplier_arbiter_tainttrack
   import multiplier_arbiter_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int TIMEOUT = 4*WIDTH+8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       req_t,
   input  logic [NUM_REQ*WIDTH-1:0] req_multiplier,
   input  logic [NUM_REQ-1:0]       req_multiplier_t,
   input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand,
   input  logic [NUM_REQ-1:0]       req_multiplicand_t,
   output logic                     mul_start,
   output logic                     mul_start_t,
   output logic [WIDTH-1:0]         mul_multiplier,
   output logic                     mul_multiplier_t,
   output logic [WIDTH-1:0]         mul_multiplicand,
   output logic                     mul_multiplicand_t,
   input  logic [2*WIDTH-1:0]       mul_product,
   input  logic                     mul_product_t,
   input  logic                     mul_productDone,
   input  logic                     mul_productDone_t,
   output logic [NUM_REQ-1:0]       resp_valid,
   output logic                     resp_valid_t,
   output logic [2*WIDTH-1:0]       resp_product,
   output logic                     resp_product_t,
   output logic                     resp_error,
   output logic                     busy
);
   localparam int CW = $clog2(TIMEOUT+1);
   localparam int IW = $clog2(NUM_REQ);
   state_e             state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d, g_q, g_d, pick_idx;
   logic               pick_found, pick_t;
   logic               grant_t_q, grant_t_d, a_t_q, a_t_d, b_t_q, b_t_d;
   logic               done_t_q, done_t_d, err_q, err_d, rp_t_q, rp_t_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] rp_q, rp_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               wd_hit;
   logic [WIDTH-1:0]   op_a [NUM_REQ];
   logic [WIDTH-1:0]   op_b [NUM_REQ];
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign op_a[i] = req_multiplier[i*WIDTH +: WIDTH];
      assign op_b[i] = req_multiplicand[i*WIDTH +: WIDTH];
   end
   rr_pick_tainttrack #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req(req), .req_t(req_t), .ptr(ptr_q),
      .found(pick_found), .idx(pick_idx), .grant_t(pick_t)
   );
   assign wd_hit = cnt_q == CW'(TIMEOUT-1);
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      g_d       = g_q;
      grant_t_d = grant_t_q;
      a_d       = a_q;
      b_d       = b_q;
      a_t_d     = a_t_q;
      b_t_d     = b_t_q;
      done_t_d  = done_t_q;
      err_d     = err_q;
      rp_d      = rp_q;
      rp_t_d    = rp_t_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: if (pick_found) begin
            state_d   = START;
            ptr_d     = pick_idx;
            g_d       = pick_idx;
            grant_t_d = pick_t;
            a_d       = op_a[pick_idx];
            b_d       = op_b[pick_idx];
            a_t_d     = req_multiplier_t[pick_idx] | pick_t;
            b_t_d     = req_multiplicand_t[pick_idx] | pick_t;
            done_t_d  = 1'b0;
            err_d     = 1'b0;
            rp_t_d    = 1'b0;
         end
         START: begin
            state_d = DRAIN;
            cnt_d   = '0;
         end
         DRAIN, RUN: begin
            cnt_d    = cnt_q + CW'(1);
            done_t_d = done_t_q | mul_productDone_t;
            // a done in RUN beats a simultaneous watchdog expiry
            if (state_q == RUN && mul_productDone) begin
               state_d = RESP;
               rp_d    = mul_product;
               rp_t_d  = mul_product_t | grant_t_q | done_t_d;
            end else if (wd_hit) begin
               state_d = RESP;
               rp_d    = '0;
               rp_t_d  = grant_t_q | done_t_d;
               err_d   = 1'b1;
            end else if (state_q == DRAIN && !mul_productDone) begin
               state_d = RUN;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         ptr_q     <= IW'(NUM_REQ-1);
         g_q       <= '0;
         grant_t_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         a_t_q     <= 1'b0;
         b_t_q     <= 1'b0;
         done_t_q  <= 1'b0;
         err_q     <= 1'b0;
         rp_q      <= '0;
         rp_t_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         g_q       <= g_d;
         grant_t_q <= grant_t_d;
         a_q       <= a_d;
         b_q       <= b_d;
         a_t_q     <= a_t_d;
         b_t_q     <= b_t_d;
         done_t_q  <= done_t_d;
         err_q     <= err_d;
         rp_q      <= rp_d;
         rp_t_q    <= rp_t_d;
         cnt_q     <= cnt_d;
      end
   end
   assign busy               = state_q != IDLE;
   assign mul_start          = state_q == START;
   assign mul_start_t        = busy & grant_t_q;
   assign mul_multiplier     = a_q;
   assign mul_multiplicand   = b_q;
   assign mul_multiplier_t   = busy & a_t_q;
   assign mul_multiplicand_t = busy & b_t_q;
   assign resp_valid         = (state_q == RESP) ? NUM_REQ'(1) << g_q : '0;
   assign resp_valid_t       = busy & (grant_t_q | done_t_q);
   assign resp_product       = rp_q;
   assign resp_product_t     = busy & rp_t_q;
   assign resp_error         = (state_q == RESP) & err_q;
endmodule

// File: tb/tb_multiplier_arbiter_tainttrack.sv
// tb_multiplier_arbiter_tainttrack: directed and random operations against a mock multiplier and a spec-level model
module tb_multiplier_arbiter_tainttrack;
   localparam int W = 8, N = 4, TO = 20;
   logic clk = 1'b0, rst = 1'b0;
   logic [N-1:0] req, req_t, req_multiplier_t, req_multiplicand_t;
   logic [N*W-1:0] req_multiplier, req_multiplicand;
   logic mul_start, mul_start_t, mul_multiplier_t, mul_multiplicand_t;
   logic [W-1:0] mul_multiplier, mul_multiplicand;
   logic [2*W-1:0] mul_product, resp_product;
   logic mul_product_t, mul_productDone, mul_productDone_t;
   logic [N-1:0] resp_valid;
   logic resp_valid_t, resp_product_t, resp_error, busy;
   int ncmp = 0, nerr = 0;
   int m_k, m_delay, m_stale, m_ptr;
   bit m_run;
   logic [2*W-1:0] m_prod;
   logic [W-1:0] opa [N];
   logic [W-1:0] opb [N];

   always #5 clk = ~clk;

   multiplier_arbiter_tainttrack #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_t(req_t),
      .req_multiplier(req_multiplier), .req_multiplier_t(req_multiplier_t),
      .req_multiplicand(req_multiplicand), .req_multiplicand_t(req_multiplicand_t),
      .mul_start(mul_start), .mul_start_t(mul_start_t),
      .mul_multiplier(mul_multiplier), .mul_multiplier_t(mul_multiplier_t),
      .mul_multiplicand(mul_multiplicand), .mul_multiplicand_t(mul_multiplicand_t),
      .mul_product(mul_product), .mul_product_t(mul_product_t),
      .mul_productDone(mul_productDone), .mul_productDone_t(mul_productDone_t),
      .resp_valid(resp_valid), .resp_valid_t(resp_valid_t),
      .resp_product(resp_product), .resp_product_t(resp_product_t),
      .resp_error(resp_error), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_ops();
      for (int i = 0; i < N; i++) begin
         req_multiplier[i*W +: W]   = opa[i];
         req_multiplicand[i*W +: W] = opb[i];
      end
   endtask

   // One clock of the mock multiplier: done rises m_delay cycles after it sees start
   task automatic tick();
      logic s;
      logic [W-1:0] a, b;
      s = mul_start;
      a = mul_multiplier;
      b = mul_multiplicand;
      @(posedge clk);
      #1;
      if (s) begin
         m_run  = 1'b1;
         m_k    = 1;
         m_prod = (2*W)'(a) * (2*W)'(b);
      end else if (m_run) m_k++;
      if (m_run) begin
         if (m_k == m_delay) begin
            mul_productDone = 1'b1;
            mul_product     = m_prod;
            m_run           = 1'b0;
         end else if (m_k == (m_stale != 0 ? m_stale : 1)) mul_productDone = 1'b0;
      end
   endtask

   function automatic int rr_model(input logic [N-1:0] rq);
      for (int k = 1; k <= N; k++) if (rq[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return 0;
   endfunction

   task automatic run_op(input string tag, input logic [N-1:0] rq, input logic [N-1:0] rqt,
                         input logic [N-1:0] at, input logic [N-1:0] bt, input int delay,
                         input int stale, input logic pt, input logic dt, input bit early);
      int g, st_i, rs_i, starts;
      bit got, ok;
      logic gt;
      logic [2*W-1:0] ep;
      g     = rr_model(rq);
      m_ptr = g;
      gt    = |(rq & rqt);
      ok    = delay <= TO;
      ep    = ok ? (2*W)'(opa[g]) * (2*W)'(opb[g]) : '0;
      req = rq; req_t = rqt; req_multiplier_t = at; req_multiplicand_t = bt;
      drive_ops();
      m_delay = delay; m_stale = stale; mul_product_t = pt; mul_productDone_t = dt;
      starts = 0; st_i = -1; rs_i = -1; got = 1'b0;
      for (int c = 0; c < 4*TO && !got; c++) begin
         tick();
         if (mul_start) begin
            starts++;
            st_i = c;
            chk({tag, ".start_t"}, mul_start_t, gt);
            chk({tag, ".opa"}, mul_multiplier, opa[g]);
            chk({tag, ".opb"}, mul_multiplicand, opb[g]);
            chk({tag, ".opa_t"}, mul_multiplier_t, at[g] | gt);
            chk({tag, ".opb_t"}, mul_multiplicand_t, bt[g] | gt);
            if (early) req[g] = 1'b0;
            req_multiplier     = (N*W)'($urandom);
            req_multiplicand   = (N*W)'($urandom);
            req_multiplier_t   = ~at;
            req_multiplicand_t = ~bt;
         end
         if (resp_valid != '0) begin
            got  = 1'b1;
            rs_i = c;
         end
      end
      chk({tag, ".resp_seen"}, got, 1);
      if (got) begin
         chk({tag, ".resp_valid"}, resp_valid, N'(1) << g);
         chk({tag, ".product"}, resp_product, ep);
         chk({tag, ".error"}, resp_error, !ok);
         chk({tag, ".latency"}, rs_i - st_i, ok ? delay + 1 : TO + 1);
         chk({tag, ".starts"}, starts, 1);
         chk({tag, ".prod_t"}, resp_product_t, ok ? (pt | gt | dt) : (gt | dt));
         chk({tag, ".valid_t"}, resp_valid_t, gt | dt);
         chk({tag, ".opa_hold"}, mul_multiplier, opa[g]);
      end
      tick();
      chk({tag, ".idle_busy"}, busy, 0);
      chk({tag, ".idle_taint"}, {mul_start_t, mul_multiplier_t, mul_multiplicand_t, resp_valid_t, resp_product_t}, 0);
   endtask

   initial begin
      req = '0; req_t = '0; req_multiplier_t = '0; req_multiplicand_t = '0;
      mul_product = '0; mul_product_t = 1'b0; mul_productDone = 1'b0; mul_productDone_t = 1'b0;
      m_run = 1'b0; m_k = 0; m_delay = 1000; m_stale = 0; m_prod = '0; m_ptr = N-1;
      for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
      drive_ops();
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", busy, 0);
      chk("rst.outs", {mul_start, resp_valid, resp_error, mul_multiplier, mul_multiplicand, resp_product}, 0);
      chk("rst.taint", {mul_start_t, mul_multiplier_t, mul_multiplicand_t, resp_valid_t, resp_product_t}, 0);
      @(negedge clk) rst = 1'b1;

      for (int i = 0; i < N; i++) begin opa[i] = W'(i + 1); opb[i] = W'(2); end
      for (int r = 0; r < 5; r++) run_op("rr", 4'b1111, '0, '0, '0, 4 + r, 0, 1'b0, 1'b0, 1'b0);

      opa[0] = 8'd3; opb[0] = 8'd5;
      run_op("single", 4'b0001, '0, '0, '0, 10, 0, 1'b0, 1'b0, 1'b0);
      run_op("taint_req", 4'b0011, 4'b0010, '0, '0, 7, 0, 1'b0, 1'b0, 1'b0);
      run_op("taint_opb", 4'b0001, '0, '0, 4'b0001, 6, 0, 1'b0, 1'b0, 1'b0);

      opa[2] = 8'd200; opb[2] = 8'd201;
      mul_productDone = 1'b1; mul_product = 16'hdead;
      run_op("stale", 4'b0100, '0, '0, '0, 8, 2, 1'b0, 1'b0, 1'b0);
      run_op("done_t", 4'b1000, '0, '0, '0, 6, 0, 1'b0, 1'b1, 1'b0);
      run_op("prod_t", 4'b0010, '0, 4'b0010, '0, 5, 0, 1'b1, 1'b0, 1'b0);
      run_op("timeout", 4'b0100, '0, '0, '0, 1000, 0, 1'b1, 1'b0, 1'b0);
      run_op("post_to", 4'b0100, '0, '0, '0, 9, 0, 1'b0, 1'b0, 1'b0);
      run_op("done_at_limit", 4'b1001, '0, '0, '0, TO, 0, 1'b0, 1'b0, 1'b0);
      run_op("done_past_limit", 4'b1001, '0, '0, '0, TO + 1, 0, 1'b0, 1'b0, 1'b0);
      run_op("early_drop", 4'b0110, '0, '0, '0, 7, 0, 1'b0, 1'b0, 1'b1);

      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < N; i++) begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
         run_op("rand", N'($urandom_range(1, 15)), N'($urandom), N'($urandom), N'($urandom),
                $urandom_range(2, 26), 0, 1'($urandom), 1'($urandom), 1'b0);
      end

      req = 4'b0100; req_t = 4'b0100; drive_ops();
      m_delay = 1000; m_stale = 0;
      for (int c = 0; c < 6; c++) tick();
      chk("rst_mid.busy_before", busy, 1);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid.busy", busy, 0);
      chk("rst_mid.outs", {mul_start, resp_valid, resp_error, mul_multiplier, resp_product}, 0);
      chk("rst_mid.taint", {mul_start_t, mul_multiplier_t, mul_multiplicand_t, resp_valid_t, resp_product_t}, 0);
      m_run = 1'b0; mul_productDone = 1'b0; m_ptr = N-1;
      @(negedge clk);
      chk("rst_mid.no_resp", resp_valid, 0);
      rst = 1'b1;
      run_op("after_rst", 4'b1011, '0, '0, '0, 5, 0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/multiplier_arbiter_tainttrack.md
Name: multiplier_arbiter_tainttrack

Overview:
Shares one taint-tracked sequential multiplier (1-bit taint per bus) between NUM_REQ requesters using round-robin arbitration. Each request is a 4-phase operation: grant, start pulse, wait for productDone, return the product. A watchdog aborts hung operations. The block sits between requester clients and the multiplier's start/productDone interface, and propagates taint conservatively, including taint from the arbitration decision itself.

Parameters:
WIDTH, 128, operand width; product is 2*WIDTH.
NUM_REQ, 4, number of requesters (2..16).
TIMEOUT, 4*WIDTH+8, maximum cycles spent in DRAIN+RUN before the operation is aborted.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request per requester; held until that requester's resp_valid
req_t  in  NUM_REQ  taint of each req bit
req_multiplier  in  NUM_REQ*WIDTH  flattened operand A; slice i belongs to requester i
req_multiplier_t  in  NUM_REQ  taint of operand A, per requester
req_multiplicand  in  NUM_REQ*WIDTH  flattened operand B
req_multiplicand_t  in  NUM_REQ  taint of operand B, per requester
mul_start  out  1  one-cycle start pulse to the multiplier
mul_start_t  out  1  taint of mul_start
mul_multiplier  out  WIDTH  registered operand A
mul_multiplier_t  out  1  taint of mul_multiplier
mul_multiplicand  out  WIDTH  registered operand B
mul_multiplicand_t  out  1  taint of mul_multiplicand
mul_product  in  2*WIDTH  multiplier result
mul_product_t  in  1  taint of mul_product
mul_productDone  in  1  multiplier completion flag
mul_productDone_t  in  1  taint of mul_productDone
resp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
resp_valid_t  out  1  taint of resp_valid
resp_product  out  2*WIDTH  registered product; valid while resp_valid is nonzero
resp_product_t  out  1  taint of resp_product
resp_error  out  1  qualifies resp_valid; 1 means the operation timed out and resp_product is 0
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE, the RR pointer goes to NUM_REQ-1, and every output and taint register clears to 0.
- States: IDLE, START, DRAIN, RUN, RESP.
- IDLE: if any req bit is high, the arbiter picks the first set bit searching from ptr+1, with wraparound. At the clock edge it:
  - latches the grant index g and operand slice g into mul_* registers;
  - sets ptr to g;
  - goes to START.
- If no req bit is high, IDLE stays.
- START: mul_start=1 for exactly 1 cycle, then DRAIN.
- DRAIN: waits for mul_productDone=0, which discards a done flag left over from the previous operation. When productDone=0 it goes to RUN.
- RUN: waits for mul_productDone=1. At the edge where done is sampled high it captures mul_product into resp_product and goes to RESP.
- RESP: resp_valid[g]=1 for 1 cycle, then IDLE. A new grant is possible in the first IDLE cycle.
- Latency: the first resp_valid cycle occurs 1 cycle after done is sampled high in RUN. The minimum from req in IDLE to resp_valid is 5 cycles.
- Watchdog:
  - The counter clears on entry to DRAIN and increments in DRAIN and RUN.
  - When count==TIMEOUT-1 and done has not been seen, the arbiter goes to RESP with resp_error=1 and resp_product=0.
  - A done sampled in the same cycle as the timeout wins: the response is normal.
- req deasserting after grant is ignored. The operation completes and resp_valid[g] still pulses.
- Operands and req changing during an operation have no effect; the mul_* operand registers hold stable from START through RESP.
- Requests from other requesters while busy are not lost, because req is level-held. They are arbitrated at the next IDLE.
- Fairness: with all req bits held high, grants follow 0,1,2,...,NUM_REQ-1,0.
- Taint (grant_t is captured at the grant edge):
  - grant_t = OR of req_t[i] over every i with req[i]=1 in the grant cycle, since the arbitration outcome depends on every competitor.
  - mul_start_t = grant_t.
  - mul_multiplier_t = req_multiplier_t[g] | grant_t; mul_multiplicand_t is defined the same way.
  - resp_product_t = mul_product_t | grant_t | done_t_seen.
  - resp_valid_t = grant_t | done_t_seen.
  - done_t_seen is the sticky OR of mul_productDone_t sampled in DRAIN and RUN. It clears at the grant edge.
  - On timeout, resp_product_t = resp_valid_t = grant_t | done_t_seen.
  - All taint outputs are 0 in IDLE.
- Reset mid-operation: the arbiter aborts immediately and no response is issued. The multiplier is reset by its own rst.

Decomposition:
- Package multiplier_arbiter_pkg holds:
  - the state enum (IDLE=0, START, DRAIN, RUN, RESP);
  - the localparam CNT_W=$clog2(TIMEOUT+1);
  - the localparam IDX_W=$clog2(NUM_REQ).
- Sub-module rr_pick_tainttrack (combinational) has inputs req, req_t and ptr, and outputs found, idx and grant_t.
- FSM, operand registers, watchdog and response registers live in the top module.

Test Plan:
- Single request: req=0001, A=3, B=5, untainted, with a mock multiplier that raises done 10 cycles after start → mul_start pulses once, resp_valid=0001 exactly 1 cycle after done is sampled, resp_product=15, resp_error=0, all taints 0.
- All req=1111 held, repeating → grant order 0,1,2,3,0; each resp_valid is one-hot to the matching slice; the product matches slice operands A=i+1, B=2.
- Taint: req=0011, req_t=0010 → requester 0 is granted, mul_start_t=1 and resp_product_t=1 despite untainted operands. Repeat with req=0001, req_multiplicand_t[0]=1 → mul_multiplicand_t=1, mul_start_t=0.
- Stale done: mock holds done=1 before start and drops it 2 cycles after start → the arbiter does not respond until done rises again; product is correct.
- Timeout with TIMEOUT=20, mock never raises done → resp_valid pulses 20 cycles after DRAIN entry, resp_error=1, resp_product=0; the next request completes normally.
- rst=0 asserted asynchronously during RUN → outputs are 0 immediately, no resp_valid; after release, a pending req is granted fresh to requester 0 (ptr reset to NUM_REQ-1).
